ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the execute-stage destination-register mux, which produces edestReg (5'd31 when ejal, otherwise rd/rt).
- Latches execute results and control into the memory stage, and substitutes the link address (PC+8) as the result for jal.
- Supports stall (hold), flush (bubble insert) and $zero write suppression, exports forwarding info, and keeps saturating retire/bubble counters.

Parameters:
- WIDTH, 32, datapath width of ALU result, store data and PC.
- CNT_W, 16, width of the retire and bubble counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage state (memory-stage back-pressure).
- flush  in  1  replace the incoming instruction with a bubble.
- evalid  in  1  execute-stage instruction valid.
- eregWrite  in  1  instruction writes the register file.
- ememToReg  in  1  writeback source is memory (load).
- ememWrite  in  1  store.
- ejal  in  1  instruction is jal.
- ealuOut  in  WIDTH  ALU result.
- ewriteData  in  WIDTH  store data (forwarded rt).
- epc8  in  WIDTH  PC+8 of the instruction.
- edestReg  in  5  destination register from the execute mux.
- mvalid  out  1  memory-stage instruction valid.
- mregWrite  out  1  effective register write enable.
- mmemToReg  out  1  load.
- mmemWrite  out  1  store.
- maluOut  out  WIDTH  address/result; PC+8 for jal.
- mwriteData  out  WIDTH  store data.
- mdestReg  out  5  destination register.
- mfwdValid  out  1  combinational: mvalid & mregWrite & !mmemToReg & (mdestReg != 0).
- retireCnt  out  CNT_W  instructions accepted.
- bubbleCnt  out  CNT_W  bubbles loaded.

Behaviour:
- Reset (async, rst=1): every registered output is 0. This covers mvalid, all control, maluOut, mwriteData, mdestReg and both counters. mfwdValid is therefore 0. Reset is effective mid-stall or mid-flush.
- Update priority on each rising edge with rst=0: flush > stall > load.
- flush=1: load a bubble. mvalid=0, mregWrite=mmemToReg=mmemWrite=0, maluOut=mwriteData=0, mdestReg=0. Flush wins over a simultaneous stall.
- stall=1, flush=0: every output and both counters hold their values.
- Load (stall=0, flush=0): latch the execute-stage values with the following rules.
  - mvalid = evalid.
  - If evalid=0, load a bubble exactly as for flush.
  - mregWrite = (eregWrite | ejal) & (edestReg != 0). Writes to $zero are suppressed.
  - mmemToReg = ememToReg; mmemWrite = ememWrite.
  - maluOut = ejal ? epc8 : ealuOut.
  - mwriteData = ewriteData; mdestReg = edestReg.
- Latency: exactly 1 cycle from execute inputs to memory outputs when not stalled.
- retireCnt increments on a load with evalid=1.
- bubbleCnt increments on any edge that loads a bubble, whether from flush or from a load with evalid=0.
- Both counters saturate at all-ones. There is no wrap and they are never cleared except by rst.
- Inputs are don't-care while stall=1 and while flush=1.
- jal combined with ememWrite=1 is an illegal decode and is passed through unchanged. No checking is done here.

Decomposition:
- Shared package/header for the core:
  - REG_RA = 5'd31 and REG_ZERO = 5'd0.
  - The bubble control encoding (all zeros).
  - A constant for the counter saturation value.
- One natural sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count).
  - Instantiated twice, for retireCnt and bubbleCnt.
  - inc is gated by the stall/flush logic in the parent.

Test Plan:
1. Reset during activity: load valid add to r5, then assert rst asynchronously between edges -> all outputs 0 immediately, without waiting for an edge; retireCnt=0.
2. jal: evalid=1, ejal=1, eregWrite=0, edestReg=31, epc8=0x0040_0010, ealuOut=0xDEAD_BEEF -> next cycle maluOut=0x0040_0010, mregWrite=1, mdestReg=31, mfwdValid=1.
3. $zero write: eregWrite=1, edestReg=0, ealuOut=0x1234 -> mregWrite=0, mfwdValid=0, mvalid=1, maluOut=0x1234; retireCnt increments.
4. Stall then flush: load lw to r8 (mfwdValid=0 because mmemToReg=1), hold stall=1 for 3 cycles with changing inputs -> outputs unchanged. Then assert stall=1 and flush=1 together -> bubble: mvalid=0, all outputs 0, bubbleCnt+1, retireCnt unchanged.
5. Bubble input: evalid=0 with eregWrite=1, edestReg=9 -> mvalid=0, mregWrite=0, mdestReg=0, bubbleCnt+1.
6. Saturation: with CNT_W=4, run 20 valid loads -> retireCnt stops at 15 and stays there on further loads.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg_pkg
// Purpose  : Shared constants and control encoding for the EX/MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_reg_pkg;

  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Counters narrower than 32 bits take their saturation value from the low bits.
  localparam logic [31:0] CNT_SAT_ALL = 32'hFFFF_FFFF;

  typedef struct packed {
    logic valid;
    logic regWrite;
    logic memToReg;
    logic memWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, regWrite: 1'b0, memToReg: 1'b0, memWrite: 1'b0};

endpackage
`default_nettype wire

// File: rtl/ex_mem_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_if
// Purpose  : Execute-to-memory stage bus, including stage stall/flush control.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic             evalid;
  logic             eregWrite;
  logic             ememToReg;
  logic             ememWrite;
  logic             ejal;
  logic [WIDTH-1:0] ealuOut;
  logic [WIDTH-1:0] ewriteData;
  logic [WIDTH-1:0] epc8;
  logic [4:0]       edestReg;

  logic             mvalid;
  logic             mregWrite;
  logic             mmemToReg;
  logic             mmemWrite;
  logic [WIDTH-1:0] maluOut;
  logic [WIDTH-1:0] mwriteData;
  logic [4:0]       mdestReg;
  logic             mfwdValid;

  modport master (
    output stall, flush, evalid, eregWrite, ememToReg, ememWrite, ejal,
           ealuOut, ewriteData, epc8, edestReg,
    input  mvalid, mregWrite, mmemToReg, mmemWrite, maluOut, mwriteData,
           mdestReg, mfwdValid
  );

  modport slave (
    input  stall, flush, evalid, eregWrite, ememToReg, ememWrite, ejal,
           ealuOut, ewriteData, epc8, edestReg,
    output mvalid, mregWrite, mmemToReg, mmemWrite, maluOut, mwriteData,
           mdestReg, mfwdValid
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; cleared only by reset.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import ex_mem_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_SAT = CNT_SAT_ALL[CNT_W-1:0];

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != c_SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg
// Purpose  : EX/MEM pipeline register with stall, flush, $zero write
//            suppression, jal link substitution and retire/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  ex_mem_if.slave               bus,
  output logic      [CNT_W-1:0] retireCnt,
  output logic      [CNT_W-1:0] bubbleCnt
);

  ctrl_t            r_ctrl;
  logic [WIDTH-1:0] r_aluOut;
  logic [WIDTH-1:0] r_writeData;
  logic [4:0]       r_destReg;

  logic  w_load;
  logic  w_take;
  logic  w_bubble;
  ctrl_t w_ctrl_next;

  // Flush overrides stall; an invalid instruction on a load is also a bubble.
  assign w_load   = !bus.flush && !bus.stall;
  assign w_take   = w_load && bus.evalid;
  assign w_bubble = bus.flush || (w_load && !bus.evalid);

  always_comb begin
    w_ctrl_next          = CTRL_BUBBLE;
    w_ctrl_next.valid    = 1'b1;
    w_ctrl_next.regWrite = (bus.eregWrite || bus.ejal) && (bus.edestReg != REG_ZERO);
    w_ctrl_next.memToReg = bus.ememToReg;
    w_ctrl_next.memWrite = bus.ememWrite;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl      <= CTRL_BUBBLE;
      r_aluOut    <= '0;
      r_writeData <= '0;
      r_destReg   <= REG_ZERO;
    end else if (w_bubble) begin
      r_ctrl      <= CTRL_BUBBLE;
      r_aluOut    <= '0;
      r_writeData <= '0;
      r_destReg   <= REG_ZERO;
    end else if (w_take) begin
      r_ctrl      <= w_ctrl_next;
      r_aluOut    <= bus.ejal ? bus.epc8 : bus.ealuOut;
      r_writeData <= bus.ewriteData;
      r_destReg   <= bus.edestReg;
    end
  end

  assign bus.mvalid     = r_ctrl.valid;
  assign bus.mregWrite  = r_ctrl.regWrite;
  assign bus.mmemToReg  = r_ctrl.memToReg;
  assign bus.mmemWrite  = r_ctrl.memWrite;
  assign bus.maluOut    = r_aluOut;
  assign bus.mwriteData = r_writeData;
  assign bus.mdestReg   = r_destReg;
  // Loads are excluded: their data is not available until after the memory stage.
  assign bus.mfwdValid  = r_ctrl.valid && r_ctrl.regWrite && !r_ctrl.memToReg
                          && (r_destReg != REG_ZERO);

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_take),
    .count (retireCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bubble),
    .count (bubbleCnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_reg
// Purpose  : Directed and randomized checks of ex_mem_reg against a rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  localparam int c_WIDTH = 32;
  localparam int c_CNT_W = 4;
  localparam int c_CNT_MAX = 15;

  logic clk;
  logic rst;
  logic [c_CNT_W-1:0] retireCnt;
  logic [c_CNT_W-1:0] bubbleCnt;

  ex_mem_if #(.WIDTH(c_WIDTH)) bus ();

  ex_mem_reg #(.WIDTH(c_WIDTH), .CNT_W(c_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .retireCnt (retireCnt),
    .bubbleCnt (bubbleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference state
  logic        m_valid, m_rw, m_m2r, m_mw;
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_dest;
  int          m_ret, m_bub;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_mw = 0;
    m_alu = 0; m_wd = 0; m_dest = 0; m_ret = 0; m_bub = 0;
  endtask

  task automatic model_edge();
    if (bus.flush || (!bus.stall && !bus.evalid)) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_mw = 0;
      m_alu = 0; m_wd = 0; m_dest = 0;
      if (m_bub < c_CNT_MAX) m_bub = m_bub + 1;
    end else if (!bus.stall) begin
      m_valid = 1;
      m_rw    = (bus.eregWrite || bus.ejal) && (bus.edestReg != 0);
      m_m2r   = bus.ememToReg;
      m_mw    = bus.ememWrite;
      m_alu   = bus.ejal ? bus.epc8 : bus.ealuOut;
      m_wd    = bus.ewriteData;
      m_dest  = bus.edestReg;
      if (m_ret < c_CNT_MAX) m_ret = m_ret + 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic fwd;
    fwd = m_valid && m_rw && !m_m2r && (m_dest != 0);
    chk({tag, ".mvalid"},    32'(bus.mvalid),     32'(m_valid));
    chk({tag, ".mregWrite"}, 32'(bus.mregWrite),  32'(m_rw));
    chk({tag, ".mmemToReg"}, 32'(bus.mmemToReg),  32'(m_m2r));
    chk({tag, ".mmemWrite"}, 32'(bus.mmemWrite),  32'(m_mw));
    chk({tag, ".maluOut"},   bus.maluOut,         m_alu);
    chk({tag, ".mwriteData"},bus.mwriteData,      m_wd);
    chk({tag, ".mdestReg"},  32'(bus.mdestReg),   32'(m_dest));
    chk({tag, ".mfwdValid"}, 32'(bus.mfwdValid),  32'(fwd));
    chk({tag, ".retireCnt"}, 32'(retireCnt),      32'(m_ret));
    chk({tag, ".bubbleCnt"}, 32'(bubbleCnt),      32'(m_bub));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                       input logic m2r, input logic mw, input logic jal,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc8, input logic [4:0] dest);
    bus.stall = st; bus.flush = fl; bus.evalid = v; bus.eregWrite = rw;
    bus.ememToReg = m2r; bus.ememWrite = mw; bus.ejal = jal;
    bus.ealuOut = alu; bus.ewriteData = wd; bus.epc8 = pc8; bus.edestReg = dest;
  endtask

  task automatic drive_random(input int p_stall, input int p_flush);
    logic jal;
    logic [4:0] dest;
    jal  = ($urandom_range(0, 7) == 0);
    dest = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    if (jal) dest = REG_RA;
    drive(($urandom_range(0, 99) < p_stall), ($urandom_range(0, 99) < p_flush),
          ($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom), 1'($urandom), jal,
          $urandom, $urandom, $urandom, dest);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int ret_before;
    n_vec = 0;
    n_err = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset during activity, asserted between edges
    drive(0, 0, 1, 1, 0, 0, 0, 32'h0000_0055, 32'h1111_2222, 32'h0040_0008, 5'd5);
    step("add_r5");
    async_reset("rst_mid");

    // jal substitutes the link address
    drive(0, 0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h0, 32'h0040_0010, REG_RA);
    step("jal");
    chk("jal.link", bus.maluOut, 32'h0040_0010);

    // $zero destination is suppressed but still retires
    ret_before = m_ret;
    drive(0, 0, 1, 1, 0, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd0);
    step("zero_wr");
    chk("zero_wr.retire_inc", 32'(retireCnt), 32'(ret_before + 1));

    // Load to r8 then stall with changing inputs, then stall+flush
    drive(0, 0, 1, 1, 1, 0, 0, 32'h1000_0040, 32'h0, 32'h0, 5'd8);
    step("lw_r8");
    for (int i = 0; i < 3; i++) begin
      drive_random(0, 0);
      bus.stall = 1'b1;
      step("stall");
    end
    drive_random(0, 0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step("stall_flush");

    // Invalid instruction becomes a bubble
    drive(0, 0, 0, 1, 0, 0, 0, 32'hAAAA_5555, 32'h0, 32'h0, 5'd9);
    step("bubble_in");

    // Reset while stalled
    drive_random(0, 0);
    bus.stall = 1'b1;
    async_reset("rst_stall");

    // Retire counter saturation
    for (int i = 0; i < 20; i++) begin
      drive_random(0, 0);
      bus.stall = 1'b0; bus.flush = 1'b0; bus.evalid = 1'b1;
      step("sat_load");
    end
    chk("sat.retire_max", 32'(retireCnt), 32'(c_CNT_MAX));

    // Randomized traffic, with a reset partway through
    for (int i = 0; i < 300; i++) begin
      if (i == 150) async_reset("rst_rand");
      drive_random(25, 10);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
